// File: rtl/tile_pkg.sv
// Shared types and defaults for the tile-matching engine.
package tile_pkg;

  localparam int unsigned NumTilesDef  = 16;
  localparam int unsigned IdxWDef      = 4;
  localparam int unsigned SymWDef      = 3;
  localparam int unsigned MissHoldDef  = 25_000_000;
  localparam int unsigned MoveLimitDef = 20;

  typedef enum logic [2:0] {
    StIdle,
    StWaitA,
    StReadA,
    StWaitB,
    StReadB,
    StCompare,
    StShowMiss,
    StDone
  } tile_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tile_hold_timer.sv
// Loadable down-counter: start loads HOLD-1, expired strobes once when the count runs out.
module tile_hold_timer
  import tile_pkg::*;
#(
  parameter int unsigned HOLD = MissHoldDef
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(HOLD + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            active_q, active_d;

  assign expired_o = active_q && (cnt_q == '0);

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (clear_i) begin
      cnt_d    = '0;
      active_d = 1'b0;
    end else if (start_i) begin
      cnt_d    = CntW'(HOLD - 1);
      active_d = 1'b1;
    end else if (expired_o) begin
      active_d = 1'b0;
    end else if (active_q) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/tile_match_engine.sv
// Tile-matching game engine: selection, symbol compare, reveal/match masks, move count.
// Optional move cap compiled in with TILE_MOVE_LIMIT_EN.
module tile_match_engine
  import tile_pkg::*;
#(
  parameter int unsigned NUM_TILES  = NumTilesDef,
  parameter int unsigned IDX_W      = IdxWDef,
  parameter int unsigned SYM_W      = SymWDef,
  parameter int unsigned MISS_HOLD  = MissHoldDef,
  parameter int unsigned MOVE_LIMIT = MoveLimitDef
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic                 ingameOn,
  input  logic                 select_valid,
  input  logic [IDX_W-1:0]     select_idx,
  output logic                 select_ready,
  output logic [IDX_W-1:0]     sym_addr,
  input  logic [SYM_W-1:0]     sym_data,
  output logic [NUM_TILES-1:0] revealed,
  output logic [NUM_TILES-1:0] matched,
  output logic [IDX_W-1:0]     pairs_left,
  output logic [7:0]           moves,
  output logic                 match_pulse,
  output logic                 miss_pulse,
  output logic                 gameOver
);

  localparam int unsigned Slots = 2 ** IDX_W;

  if ((NUM_TILES % 2) != 0 || Slots < NUM_TILES) begin : g_bad_tiles
    $error("tile_match_engine: NUM_TILES must be even and fit in IDX_W bits");
  end
  if (MISS_HOLD < 1 || MOVE_LIMIT > 255) begin : g_bad_limits
    $error("tile_match_engine: MISS_HOLD must be >= 1 and MOVE_LIMIT <= 255");
  end

  tile_state_e state_q, state_d;

  logic                 phase_q, phase_d;
  logic [IDX_W-1:0]     idx_a_q, idx_a_d, idx_b_q, idx_b_d, sym_addr_q, sym_addr_d;
  logic [SYM_W-1:0]     sym_a_q, sym_a_d, sym_b_q, sym_b_d;
  logic [NUM_TILES-1:0] revealed_q, revealed_d, matched_q, matched_d;
  logic [IDX_W-1:0]     pairs_left_q, pairs_left_d;
  logic [7:0]           moves_q, moves_d, moves_inc;
  logic                 match_q, match_d, miss_q, miss_d, ready_q, ready_d, over_q, over_d;

  logic [Slots-1:0]     rev_pad;
  logic [NUM_TILES-1:0] sel_mask, pair_mask;
  logic                 sel_ok, is_eq, final_match, limit_hit, hold_start, hold_expired;

  // Index through a full-width copy so out-of-range indices stay legal.
  assign rev_pad     = Slots'(revealed_q);
  assign sel_ok      = select_valid && (32'(select_idx) < NUM_TILES) && !rev_pad[select_idx];
  assign sel_mask    = NUM_TILES'(1) << select_idx;
  assign pair_mask   = (NUM_TILES'(1) << idx_a_q) | (NUM_TILES'(1) << idx_b_q);
  assign is_eq       = (sym_a_q == sym_b_q);
  assign final_match = is_eq && (pairs_left_q == IDX_W'(1));
  assign moves_inc   = sat_inc8(moves_q);

`ifdef TILE_MOVE_LIMIT_EN
  assign limit_hit = (moves_inc >= 8'(MOVE_LIMIT));
`else
  assign limit_hit = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     state_d = StWaitA;
      StWaitA:    if (sel_ok) state_d = StReadA;
      StReadA:    if (phase_q) state_d = StWaitB;
      StWaitB:    if (sel_ok) state_d = StReadB;
      StReadB:    if (phase_q) state_d = StCompare;
      StCompare: begin
        if (final_match || limit_hit) state_d = StDone;
        else if (is_eq)               state_d = StWaitA;
        else                          state_d = StShowMiss;
      end
      StShowMiss: if (hold_expired) state_d = StWaitA;
      StDone:     state_d = StDone;
      default:    state_d = StIdle;
    endcase
    // Leaving the in-game mode wins over every other transition.
    if (!ingameOn) state_d = StIdle;
  end

  always_comb begin
    phase_d      = 1'b0;
    idx_a_d      = idx_a_q;
    idx_b_d      = idx_b_q;
    sym_addr_d   = sym_addr_q;
    sym_a_d      = sym_a_q;
    sym_b_d      = sym_b_q;
    revealed_d   = revealed_q;
    matched_d    = matched_q;
    pairs_left_d = pairs_left_q;
    moves_d      = moves_q;
    match_d      = 1'b0;
    miss_d       = 1'b0;
    if (!ingameOn || state_q == StIdle) begin
      revealed_d   = '0;
      matched_d    = '0;
      moves_d      = '0;
      pairs_left_d = IDX_W'(NUM_TILES / 2);
    end else begin
      case (state_q)
        StWaitA, StWaitB: begin
          if (sel_ok) begin
            if (state_q == StWaitA) idx_a_d = select_idx;
            else                    idx_b_d = select_idx;
            sym_addr_d = select_idx;
            revealed_d = revealed_q | sel_mask;
          end
        end
        StReadA: begin
          phase_d = !phase_q;
          if (phase_q) sym_a_d = sym_data;
        end
        StReadB: begin
          phase_d = !phase_q;
          if (phase_q) sym_b_d = sym_data;
        end
        StCompare: begin
          moves_d = moves_inc;
          if (is_eq) begin
            matched_d    = matched_q | pair_mask;
            pairs_left_d = pairs_left_q - 1'b1;
            match_d      = 1'b1;
          end else begin
            miss_d = 1'b1;
          end
        end
        StShowMiss: if (hold_expired) revealed_d = revealed_q & ~pair_mask;
        default: ;
      endcase
    end
    ready_d = (state_d == StWaitA) || (state_d == StWaitB);
    over_d  = (state_d == StDone);
  end

  assign hold_start = (state_q == StCompare) && (state_d == StShowMiss);

  tile_hold_timer #(
    .HOLD (MISS_HOLD)
  ) u_hold_timer (
    .clk_i     (CLOCK_50),
    .rst_ni    (resetn),
    .start_i   (hold_start),
    .clear_i   (!ingameOn),
    .expired_o (hold_expired)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      phase_q      <= 1'b0;
      idx_a_q      <= '0;
      idx_b_q      <= '0;
      sym_addr_q   <= '0;
      sym_a_q      <= '0;
      sym_b_q      <= '0;
      revealed_q   <= '0;
      matched_q    <= '0;
      pairs_left_q <= IDX_W'(NUM_TILES / 2);
      moves_q      <= '0;
      match_q      <= 1'b0;
      miss_q       <= 1'b0;
      ready_q      <= 1'b0;
      over_q       <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      idx_a_q      <= idx_a_d;
      idx_b_q      <= idx_b_d;
      sym_addr_q   <= sym_addr_d;
      sym_a_q      <= sym_a_d;
      sym_b_q      <= sym_b_d;
      revealed_q   <= revealed_d;
      matched_q    <= matched_d;
      pairs_left_q <= pairs_left_d;
      moves_q      <= moves_d;
      match_q      <= match_d;
      miss_q       <= miss_d;
      ready_q      <= ready_d;
      over_q       <= over_d;
    end
  end

  assign select_ready = ready_q;
  assign sym_addr     = sym_addr_q;
  assign revealed     = revealed_q;
  assign matched      = matched_q;
  assign pairs_left   = pairs_left_q;
  assign moves        = moves_q;
  assign match_pulse  = match_q;
  assign miss_pulse   = miss_q;
  assign gameOver     = over_q;

endmodule

// File: tb/tb_tile_match_engine.sv
// Directed bench for tile_match_engine with a pair-outcome scoreboard.
module tb_tile_match_engine;

  localparam int unsigned HOLD = 4;

  logic        CLOCK_50 = 1'b0;
  logic        resetn = 1'b0;
  logic        ingameOn = 1'b1;
  logic        select_valid = 1'b0;
  logic [3:0]  select_idx = '0;
  logic        select_ready;
  logic [3:0]  sym_addr;
  logic [2:0]  sym_data = '0;
  logic [15:0] revealed, matched;
  logic [3:0]  pairs_left;
  logic [7:0]  moves;
  logic        match_pulse, miss_pulse, gameOver;

  logic        s_valid = 1'b0;
  logic [3:0]  s_idx = '0;
  logic        s_ready;
  logic [3:0]  s_sym_addr;
  logic [2:0]  s_sym_data = '0;
  logic [11:0] s_revealed, s_matched;
  logic [3:0]  s_pairs_left;
  logic [7:0]  s_moves;
  logic        s_match, s_miss, s_over;

  int n_cmp = 0;
  int n_err = 0;
  int exp_moves = 0;
  int exp_pairs = 8;
  bit sb_q[$];

  always #5 CLOCK_50 = ~CLOCK_50;

  // Board layout: pairs (0,1) (2,4) (3,5) (6,7) (8,10) (9,11) (12,14) (13,15).
  function automatic logic [2:0] sym_of(input logic [3:0] a);
    case (a)
      4'd0, 4'd1:   return 3'd0;
      4'd2, 4'd4:   return 3'd1;
      4'd3, 4'd5:   return 3'd2;
      4'd6, 4'd7:   return 3'd3;
      4'd8, 4'd10:  return 3'd4;
      4'd9, 4'd11:  return 3'd5;
      4'd12, 4'd14: return 3'd6;
      default:      return 3'd7;
    endcase
  endfunction

  always @(posedge CLOCK_50) begin
    sym_data   <= sym_of(sym_addr);
    s_sym_data <= sym_of(s_sym_addr);
  end

  tile_match_engine #(
    .NUM_TILES  (16),
    .IDX_W      (4),
    .SYM_W      (3),
    .MISS_HOLD  (HOLD),
    .MOVE_LIMIT (3)
  ) u_dut (
    .CLOCK_50     (CLOCK_50),
    .resetn       (resetn),
    .ingameOn     (ingameOn),
    .select_valid (select_valid),
    .select_idx   (select_idx),
    .select_ready (select_ready),
    .sym_addr     (sym_addr),
    .sym_data     (sym_data),
    .revealed     (revealed),
    .matched      (matched),
    .pairs_left   (pairs_left),
    .moves        (moves),
    .match_pulse  (match_pulse),
    .miss_pulse   (miss_pulse),
    .gameOver     (gameOver)
  );

  tile_match_engine #(
    .NUM_TILES  (12),
    .IDX_W      (4),
    .SYM_W      (3),
    .MISS_HOLD  (HOLD),
    .MOVE_LIMIT (3)
  ) u_small (
    .CLOCK_50     (CLOCK_50),
    .resetn       (resetn),
    .ingameOn     (ingameOn),
    .select_valid (s_valid),
    .select_idx   (s_idx),
    .select_ready (s_ready),
    .sym_addr     (s_sym_addr),
    .sym_data     (s_sym_data),
    .revealed     (s_revealed),
    .matched      (s_matched),
    .pairs_left   (s_pairs_left),
    .moves        (s_moves),
    .match_pulse  (s_match),
    .miss_pulse   (s_miss),
    .gameOver     (s_over)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (resetn && (match_pulse || miss_pulse)) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_pulse", 32'(sb_q.size()), 1);
      end else begin
        bit exp_m;
        exp_m = sb_q.pop_front();
        check("sb_outcome", {match_pulse, miss_pulse}, exp_m ? 2'b10 : 2'b01);
      end
    end
  end

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!select_ready && n < budget) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("ready_wait", select_ready, 1);
  endtask

  task automatic select(input int idx);
    wait_ready(8);
    select_valid = 1'b1;
    select_idx   = 4'(idx);
    @(negedge CLOCK_50);
    select_valid = 1'b0;
  endtask

  task automatic do_pair(input int a, input int b, input bit exp_match, input bit exp_done,
                         input bit retry_a);
    select(a);
    if (retry_a) begin
      wait_ready(8);
      select_valid = 1'b1;
      select_idx   = 4'(a);
      @(negedge CLOCK_50);
      select_valid = 1'b0;
      check("retry_b_ready", select_ready, 1);
      check("retry_b_addr", sym_addr, 32'(a));
    end
    select(b);
    check("sel_addr", sym_addr, 32'(b));
    check("sel_rev", {revealed[a], revealed[b]}, 2'b11);
    exp_moves++;
    if (exp_match) exp_pairs--;
    sb_q.push_back(exp_match);
    repeat (2) @(negedge CLOCK_50);
    check("pulse_early", {match_pulse, miss_pulse, gameOver}, 3'b000);
    @(negedge CLOCK_50);
    if (exp_match) check("match_pulse", match_pulse, 1);
    else           check("miss_pulse", miss_pulse, 1);
    check("moves", moves, 32'(exp_moves));
    check("pairs_left", pairs_left, 32'(exp_pairs));
    check("game_over", gameOver, 32'(exp_done));
    if (exp_match) check("matched_pair", {matched[a], matched[b]}, 2'b11);
    if (!exp_match && !exp_done) begin
      for (int i = 0; i < int'(HOLD) - 1; i++) begin
        @(negedge CLOCK_50);
        check("hold_rev", {revealed[a], revealed[b], select_ready}, 3'b110);
        select_valid = (i == 0);
        select_idx   = 4'd15;
      end
      select_valid = 1'b0;
      @(negedge CLOCK_50);
      check("hold_clear", {revealed[a], revealed[b], revealed[15]}, 3'b000);
      check("hold_ready", select_ready, 1);
    end else begin
      check("ready_after", select_ready, 32'(!exp_done));
    end
  endtask

  task automatic drop_game();
    ingameOn = 1'b0;
    @(negedge CLOCK_50);
    check("drop_masks", {revealed, matched}, 32'h0);
    check("drop_over", {gameOver, select_ready}, 2'b00);
    check("drop_counts", {pairs_left, moves}, {4'd8, 8'd0});
    ingameOn  = 1'b1;
    exp_moves = 0;
    exp_pairs = 8;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish within 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge CLOCK_50);
    check("rst_flags", {select_ready, match_pulse, miss_pulse, gameOver}, 4'b0000);
    check("rst_masks", {revealed, matched}, 32'h0);
    check("rst_counts", {pairs_left, moves, sym_addr}, {4'd8, 8'd0, 4'd0});
    resetn = 1'b1;
    wait_ready(2);

    // Out-of-range indices on a 12-tile board are ignored; tile 11 is accepted.
    s_valid = 1'b1;
    s_idx   = 4'd12;
    @(negedge CLOCK_50);
    s_idx = 4'd15;
    @(negedge CLOCK_50);
    s_valid = 1'b0;
    check("small_oor", {s_revealed, s_sym_addr, s_ready}, {12'h000, 4'd0, 1'b1});
    s_valid = 1'b1;
    s_idx   = 4'd11;
    @(negedge CLOCK_50);
    s_valid = 1'b0;
    check("small_accept", {s_revealed, s_sym_addr}, {12'h800, 4'd11});

    do_pair(0, 1, 1'b1, 1'b0, 1'b0);
    do_pair(2, 3, 1'b0, 1'b0, 1'b0);

    // Reselecting an already-revealed tile changes nothing.
    select_valid = 1'b1;
    select_idx   = 4'd0;
    @(negedge CLOCK_50);
    select_valid = 1'b0;
    @(negedge CLOCK_50);
    check("reselect", {revealed, sym_addr, select_ready}, {16'h0003, 4'd3, 1'b1});
    check("reselect_moves", moves, 2);

`ifdef TILE_MOVE_LIMIT_EN
    drop_game();
    do_pair(2, 3, 1'b0, 1'b0, 1'b0);
    do_pair(2, 3, 1'b0, 1'b0, 1'b0);
    do_pair(2, 3, 1'b0, 1'b1, 1'b0);
    repeat (HOLD + 2) @(negedge CLOCK_50);
    check("limit_hold", {gameOver, revealed[3], revealed[2], select_ready}, 4'b1110);
    drop_game();
`else
    do_pair(2, 4, 1'b1, 1'b0, 1'b1);
    do_pair(3, 5, 1'b1, 1'b0, 1'b0);
    do_pair(6, 7, 1'b1, 1'b0, 1'b0);
    do_pair(8, 10, 1'b1, 1'b0, 1'b0);
    do_pair(9, 11, 1'b1, 1'b0, 1'b0);
    do_pair(12, 14, 1'b1, 1'b0, 1'b0);
    do_pair(13, 15, 1'b1, 1'b1, 1'b0);
    check("all_matched", matched, 32'h0000_FFFF);
    @(negedge CLOCK_50);
    check("over_held", {gameOver, select_ready}, 2'b10);
    drop_game();
`endif

    check("sb_drained", 32'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tile_match_engine.md
# tile_match_engine

Core gameplay engine of the tile-matching game. Enabled by `ingameOn` from the game-mode FSM, it accepts player tile selections and reads tile symbols from the board layout ROM. It compares each pair, tracks revealed and matched tiles, and counts moves. It raises `gameOver` back to the game-mode FSM when every pair is matched, or when the move limit is hit if that feature is compiled in.

## Interface
- `NUM_TILES`, 16: tiles on the board; must be even; `NUM_TILES/2` pairs.
- `IDX_W`, 4: tile index width; `2**IDX_W >= NUM_TILES`.
- `SYM_W`, 3: symbol code width.
- `MISS_HOLD`, 25_000_000: cycles a mismatched pair stays revealed (0.5 s at 50 MHz); must be ≥1.
- `MOVE_LIMIT`, 20: move cap; used only with `TILE_MOVE_LIMIT_EN`.

Ports:
- `CLOCK_50`  in  1  system clock, 50 MHz.
- `resetn`  in  1  asynchronous, active-low reset.
- `ingameOn`  in  1  high while the game-mode FSM is in the in-game mode.
- `select_valid`  in  1  one-cycle selection strobe from key/cursor logic.
- `select_idx`  in  IDX_W  selected tile index.
- `select_ready`  out  1  engine can accept a selection.
- `sym_addr`  out  IDX_W  layout ROM address, registered.
- `sym_data`  in  SYM_W  layout ROM data, valid 1 cycle after `sym_addr`.
- `revealed`  out  NUM_TILES  face-up tiles for VGA; includes matched tiles.
- `matched`  out  NUM_TILES  permanently matched tiles.
- `pairs_left`  out  IDX_W  pairs remaining.
- `moves`  out  8  completed pair attempts; saturates at 255.
- `match_pulse`  out  1  one-cycle strobe when a pair matches.
- `miss_pulse`  out  1  one-cycle strobe when a pair mismatches.
- `gameOver`  out  1  level; held until `ingameOn` falls.

## Operation
- States: IDLE, WAIT_A, READ_A, WAIT_B, READ_B, COMPARE, SHOW_MISS, DONE.
- IDLE: clears all masks and counters and sets `pairs_left` to `NUM_TILES/2`. Moves to WAIT_A when `ingameOn` is 1.
- WAIT_A and WAIT_B: `select_ready` is 1.
  - A selection is accepted when `select_valid && select_ready` and the tile is valid.
  - Invalid tile: `select_idx >= NUM_TILES`, or its `revealed` bit is already set. An invalid selection is ignored silently; the state is unchanged and nothing is counted.
  - On acceptance: latch the index, register `sym_addr`, set the `revealed` bit, and go to READ_x.
- READ_A and READ_B: wait one cycle, then latch `sym_data` on the second cycle.
  - READ_A exits to WAIT_B.
  - READ_B exits to COMPARE.
- COMPARE, 1 cycle:
  - `moves` increments, saturating.
  - Equal symbols: set both `matched` bits, decrement `pairs_left`, pulse `match_pulse`. Go to DONE if `pairs_left` reaches 0, else WAIT_A.
  - Unequal symbols: pulse `miss_pulse` and go to SHOW_MISS.
- SHOW_MISS: hold for `MISS_HOLD` cycles, then clear both `revealed` bits and go to WAIT_A. Selections are ignored throughout.
- DONE: `gameOver` is 1 and `select_ready` is 0.
- `ingameOn` low in any state: go to IDLE on the next edge. Masks clear there and `gameOver` drops. This overrides every other transition, including COMPARE in the same cycle.

## Timing
- Reset values:
  - state IDLE.
  - `select_ready`, `match_pulse`, `miss_pulse`, `gameOver` all 0.
  - `revealed`, `matched`, `moves`, `sym_addr` all 0.
  - `pairs_left` = `NUM_TILES/2`.
- Selection accepted at edge k: `sym_addr` and `revealed` update at k; symbol latched at k+2.
- Second selection accepted at edge k: COMPARE occupies cycle k+2..k+3.
  - `match_pulse`, `miss_pulse` and the `matched` update are visible after edge k+3.
  - `select_ready` returns at k+3 on a match.
  - On a mismatch, `select_ready` returns `MISS_HOLD` cycles later.
- Outputs are all registered; there are no combinational paths from inputs to outputs.
- `gameOver` rises the cycle after COMPARE on the final match.

## Configuration
- `TILE_MOVE_LIMIT_EN` defined: in COMPARE, a non-final mismatch or match that brings `moves` to `MOVE_LIMIT` goes to DONE and asserts `gameOver`. `matched` keeps its state; no SHOW_MISS.
- `TILE_MOVE_LIMIT_EN` undefined: `MOVE_LIMIT` is ignored; the game ends only when all pairs are matched.

## Structure
- Shared package `tile_pkg`: state enum encoding, default `NUM_TILES`, `IDX_W`, `SYM_W`, `MISS_HOLD`.
- Sub-module `tile_hold_timer`:
  - Loadable down-counter.
  - `start` pulse loads `MISS_HOLD-1`.
  - `expired` is a one-cycle strobe.
  - Instantiated once for SHOW_MISS.

## Test plan
- Reset with `resetn`=0 → all outputs at reset values, `pairs_left`=8; release with `ingameOn`=1 → `select_ready`=1 within 2 cycles.
- Select tiles 0 then 1 with equal ROM symbols → `match_pulse` at k+3, `matched[1:0]`=2'b11, `pairs_left`=7, `moves`=1.
- Select tiles 2 then 3 with different symbols, `MISS_HOLD`=4 → `miss_pulse`, `revealed[3:2]` set for 4 cycles then cleared; a selection during the hold is ignored.
- Reselect a revealed tile, or `select_idx`=15 with `NUM_TILES`=12 → no state change, `moves` unchanged.
- Match all 8 pairs → `gameOver`=1 one cycle after the final COMPARE; drop `ingameOn` → IDLE, masks 0, `gameOver`=0 next edge.
- With `TILE_MOVE_LIMIT_EN` and `MOVE_LIMIT`=3, three mismatches → `gameOver`=1 after the third COMPARE, no SHOW_MISS.
